mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit: radix-2 Booth multiply and restoring divide, WIDTH cycles each.
// Optional macro MULT_DIV_UNSIGNED_EN adds the is_unsigned input for multu/divu.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH+1:0]   acc;     // Booth partial product, or {0, remainder} when dividing
  logic [WIDTH+1:0]   mcand;   // multiplicand, or divisor magnitude when dividing
  logic [WIDTH-1:0]   q;       // multiplier shifting out, or dividend/quotient when dividing
  logic               q_1;
  logic               uns, b_msb, neg_q, neg_r;
  logic               uns_in;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   booth_sum, mul_acc_n;
  logic [WIDTH-1:0]   mul_q_n, mul_hi;
  logic [WIDTH:0]     div_shift, div_rem_n;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH-1:0]   div_quo_n, div_lo, div_hi;

  assign a_mag = (!uns_in && A[WIDTH-1]) ? -A : A;
  assign b_mag = (!uns_in && B[WIDTH-1]) ? -B : B;

  // One iteration of each algorithm, evaluated from the current registers.
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    mul_acc_n = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
    mul_q_n   = {booth_sum[0], q[WIDTH-1:1]};
    // Booth treats the multiplier as signed; an unsigned multiplier with its MSB set needs M*2^WIDTH added back.
    mul_hi    = mul_acc_n[WIDTH-1:0] + ((uns && b_msb) ? mcand[WIDTH-1:0] : '0);

    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, mcand[WIDTH-1:0]};
    if (!div_trial[WIDTH+1]) begin
      div_rem_n = div_trial[WIDTH:0];
      div_quo_n = {q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_n = div_shift;
      div_quo_n = {q[WIDTH-2:0], 1'b0};
    end
    div_lo = neg_q ? -div_quo_n : div_quo_n;
    div_hi = neg_r ? -div_rem_n[WIDTH-1:0] : div_rem_n[WIDTH-1:0];
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (start) state_next = !op ? MULT : ((B == '0) ? DONE : DIV);
      MULT: if (cnt == '0) state_next = DONE;
      DIV:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == MULT) || (state_next == DIV);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      uns      <= 1'b0;
      b_msb    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt      <= CW'(WIDTH - 1);
          acc      <= '0;
          q_1      <= 1'b0;
          uns      <= uns_in;
          b_msb    <= B[WIDTH-1];
          neg_q    <= !uns_in && (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_r    <= !uns_in && A[WIDTH-1];
          div_zero <= op && (B == '0);
          if (!op) begin
            mcand <= uns_in ? {2'b00, A} : {{2{A[WIDTH-1]}}, A};
            q     <= B;
          end else begin
            mcand <= {2'b00, b_mag};
            q     <= a_mag;
          end
        end
        MULT: begin
          acc <= mul_acc_n;
          q   <= mul_q_n;
          q_1 <= q[0];
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            hi <= mul_hi;
            lo <= mul_q_n;
          end
        end
        DIV: begin
          acc <= {1'b0, div_rem_n};
          q   <= div_quo_n;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            hi <= div_hi;
            lo <= div_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expected results, a monitor checks on done.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] A, B;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
`ifdef MULT_DIV_UNSIGNED_EN
  logic         is_unsigned = 1'b0;
`endif

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
`ifdef MULT_DIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .A(A), .B(B), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_hi", e.id), 64'(hi), 64'(e.hi));
        check($sformatf("op%0d_lo", e.id), 64'(lo), 64'(e.lo));
        check($sformatf("op%0d_div_zero", e.id), 64'(div_zero), 64'(e.dz));
        check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.cyc));
        check($sformatf("op%0d_busy_at_done", e.id), 64'(busy), 64'd0);
      end
    end
  end

  int op_id = 0;

  // Issue one operation, push its expectation, wait (bounded) for done, and count busy cycles.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_dz,
                        input bit disturb);
    exp_t e;
    int   nb;
    bit   seen;
    int   lat;
    lat = (o && b == '0) ? 0 : W;
    @(negedge clock);
    start = 1'b1; op = o; A = a; B = b;
    e.id = op_id; e.hi = e_hi; e.lo = e_lo; e.dz = e_dz; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    nb = 0; seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clock);
      start = 1'b0;
      A = $urandom; B = $urandom;
      if (disturb && k == 10) begin
        start = 1'b1; op = ~o; A = 32'h0000_0003; B = 32'h0000_0000;
      end
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) nb++;
    end
    start = 1'b0;
    if (!seen) check($sformatf("op%0d_timeout", op_id), 64'd0, 64'd1);
    check($sformatf("op%0d_busy_cycles", op_id), 64'(nb), 64'(lat));
    op_id++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);

    run_op(1'b0, 32'd7, -32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op(1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(1'b0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1'b0);
    run_op(1'b1, 32'd10, 32'd0, 32'h0, 32'd15, 1'b1, 1'b0);
    @(negedge clock);
    check("div_zero_held_idle", 64'(div_zero), 64'd1);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    run_op(1'b1, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(1'b1, -32'sd7, -32'sd2, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
    run_op(1'b1, 32'd5, 32'd7, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd1, 1'b0, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    // Abort a divide with reset mid-iteration; no completion is expected for it.
    @(negedge clock);
    start = 1'b1; op = 1'b1; A = 32'd100; B = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
